peak_level_meter: RTL and testbench
===================================

Name: peak_level_meter

Overview:
Parametrised successor to the single-bar volume meter. Consumes offset-binary ADC samples on a qualified strobe. Each sample is converted to magnitude about a configurable midpoint, and the peak is tracked over a window of N accepted samples. At window close it publishes a thermometer bar, a numeric level, and a peak-hold marker that decays after a hold period. It sits between the mic ADC sampler and the OLED/LED display drivers.

Parameters:
SAMPLE_W, 12, ADC sample width in bits
MIDPOINT, 2048, zero-signal ADC code (offset-binary centre)
WINDOW, 2000, accepted samples per measurement window (>=2)
NUM_LEVELS, 16, bar segments (1..32)
LEVEL_SHIFT, 7, log2 of magnitude per segment
HOLD_WINDOWS, 4, windows the peak-hold marker stays before decaying (>=0)
LW, $clog2(NUM_LEVELS+1), derived level-index width (localparam)

Ports:
cs  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high
sample_valid  in  1  qualifies sample this cycle
sample  in  SAMPLE_W  unsigned offset-binary ADC code
volume_level  out  NUM_LEVELS  thermometer bar, bit i lit iff level > i
level  out  LW  current window level, 0..NUM_LEVELS
hold_level  out  LW  peak-hold marker level
window_done  out  1  one-cycle pulse when outputs update

Behaviour:
- Reset (reset=1 at posedge) clears window counter, running max, window peak, hold counter and every output to 0. The in-flight window is discarded. The first window after reset begins with the first accepted sample.
- Samples are accepted only when sample_valid=1. Idle cycles change nothing except stage-2 outputs and the window_done pulse.
- Magnitude, combinational: mag = (sample>=MIDPOINT) ? sample-MIDPOINT : MIDPOINT-sample. Width SAMPLE_W, no overflow for MIDPOINT <= 2^SAMPLE_W-1.
- Stage 1, on each accepted sample:
  - If cnt == WINDOW-1: peak_r <= max(run_max, mag), so the closing sample is included. run_max <= 0, cnt <= 0, close_r <= 1.
  - Else: run_max <= max(run_max, mag), cnt <= cnt+1.
  - cnt width $clog2(WINDOW). close_r is 0 in every other cycle.
- Stage 2, in the cycle after close_r=1:
  - lvl = min(peak_r >> LEVEL_SHIFT, NUM_LEVELS).
  - level <= lvl; volume_level <= (1<<lvl)-1, with all ones when lvl=NUM_LEVELS.
  - window_done <= 1 for exactly one cycle.
  - Latency: outputs update 2 cycles after the posedge that accepts the window's last sample.
- Peak hold, evaluated in the same stage-2 cycle:
  - lvl >= hold_level: hold_level <= lvl, hold_cnt <= HOLD_WINDOWS.
  - Else if hold_cnt > 0: hold_cnt <= hold_cnt-1, hold_level unchanged.
  - Else: hold_level <= hold_level-1. It decays one level per window and never drops below lvl: use max(hold_level-1, lvl).
  - HOLD_WINDOWS=0 means decay starts the next window.
- Outputs are held between window_done pulses.
- Boundaries:
  - sample==MIDPOINT gives mag 0.
  - sample 0 with MIDPOINT 2048 gives mag 2048, level 16, full bar.
  - mag exactly k<<LEVEL_SHIFT gives level k (inclusive threshold).
  - reset asserted in the same cycle as a closing sample: reset wins, and no window_done is produced.
  - Back-to-back valid samples every cycle are supported with no stall.
  - Windows with idle gaps simply take longer.

Decomposition:
- No shared package types are needed.
- LW and the cnt width are localparams.
- One natural sub-module: peak_hold_tracker (level in, update strobe, hold_level out, HOLD_WINDOWS parameter). It is reused by the future per-band FFT bar display.
- Magnitude and thermometer encode stay inline.

Test Plan:
- Reset: WINDOW=8. Assert reset 3 cycles mid-window, then release -> all outputs 0, no window_done until 8 further valid samples.
- Window ramp: WINDOW=8, samples 2048,2100,2300,2048,2048,2048,2048,3000 (last sample closing) -> peak 952, level=7, volume_level=16'h007F. window_done exactly 2 cycles after the 8th accept.
- Negative swing and saturation: one window containing sample 0 -> level=16, volume_level=16'hFFFF. One window containing sample 1152 (mag 896) -> level=7.
- Threshold edge: windows with max mag 767 and 768 -> level 5 then level 6.
- Valid gating: same 8 samples as the ramp test, with sample_valid low on alternate cycles and garbage on the data bus (e.g. 0) during invalid cycles -> result identical to the ramp test, window_done delayed accordingly.
- Peak hold, HOLD_WINDOWS=2: window levels 10,3,3,3,3,3 -> hold_level 10,10,10,9,8,7. Then a level-12 window -> hold_level=12 immediately.

Source files
------------

// File: rtl/peak_level_meter_pkg.sv
// Shared helpers for the peak level meter and its peak-hold tracker.
package peak_level_meter_pkg;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/peak_level_meter_peak_hold_tracker.sv
// Peak-hold marker: jumps up to any louder level, holds for HOLD_WINDOWS
// updates, then decays one level per update but never below the live level.
module peak_hold_tracker
  import peak_level_meter_pkg::*;
#(
  parameter int unsigned LW           = 5,
  parameter int unsigned HOLD_WINDOWS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          update,
  input  logic [LW-1:0] level_in,
  output logic [LW-1:0] hold_level
);

  localparam int unsigned HCW = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;

  logic [LW-1:0]  hold_level_q, hold_level_d;
  logic [HCW-1:0] hold_cnt_q,   hold_cnt_d;

  always_comb begin
    hold_level_d = hold_level_q;
    hold_cnt_d   = hold_cnt_q;
    if (update) begin
      if (level_in >= hold_level_q) begin
        hold_level_d = level_in;
        hold_cnt_d   = HCW'(HOLD_WINDOWS);
      end else if (hold_cnt_q != '0) begin
        hold_cnt_d = hold_cnt_q - HCW'(1);
      end else begin
        hold_level_d = LW'(max_u(32'(hold_level_q) - 32'd1, 32'(level_in)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_level_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      hold_level_q <= hold_level_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign hold_level = hold_level_q;

endmodule

// File: rtl/peak_level_meter.sv
// Windowed peak level meter: magnitude about MIDPOINT, per-window peak,
// thermometer bar plus numeric level and a decaying peak-hold marker.
module peak_level_meter
  import peak_level_meter_pkg::*;
#(
  parameter int unsigned SAMPLE_W     = 12,
  parameter int unsigned MIDPOINT     = 2048,
  parameter int unsigned WINDOW       = 2000,
  parameter int unsigned NUM_LEVELS   = 16,
  parameter int unsigned LEVEL_SHIFT  = 7,
  parameter int unsigned HOLD_WINDOWS = 4,
  localparam int unsigned LW          = $clog2(NUM_LEVELS + 1)
) (
  input  logic                  cs,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [SAMPLE_W-1:0]   sample,
  output logic [NUM_LEVELS-1:0] volume_level,
  output logic [LW-1:0]         level,
  output logic [LW-1:0]         hold_level,
  output logic                  window_done
);

  localparam int unsigned CNT_W = $clog2(WINDOW);

  logic [CNT_W-1:0]      cnt_q,          cnt_d;
  logic [SAMPLE_W-1:0]   run_max_q,      run_max_d;
  logic [SAMPLE_W-1:0]   peak_q,         peak_d;
  logic                  close_q,        close_d;
  logic [LW-1:0]         level_q,        level_d;
  logic [NUM_LEVELS-1:0] volume_level_q, volume_level_d;
  logic                  window_done_q,  window_done_d;

  logic [SAMPLE_W-1:0] mag;
  logic [SAMPLE_W-1:0] mag_max;
  logic [LW-1:0]       lvl;

  always_comb begin
    mag     = (sample >= SAMPLE_W'(MIDPOINT)) ? (sample - SAMPLE_W'(MIDPOINT))
                                              : (SAMPLE_W'(MIDPOINT) - sample);
    mag_max = (mag > run_max_q) ? mag : run_max_q;

    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    peak_d    = peak_q;
    close_d   = 1'b0;
    if (sample_valid) begin
      // The closing sample folds into the published peak, not the next window.
      if (cnt_q == CNT_W'(WINDOW - 1)) begin
        peak_d    = mag_max;
        run_max_d = '0;
        cnt_d     = '0;
        close_d   = 1'b1;
      end else begin
        run_max_d = mag_max;
        cnt_d     = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    lvl            = LW'(min_u(32'(peak_q) >> LEVEL_SHIFT, NUM_LEVELS));
    level_d        = level_q;
    volume_level_d = volume_level_q;
    window_done_d  = close_q;
    if (close_q) begin
      level_d = lvl;
      for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
        volume_level_d[i] = (32'(lvl) > i);
      end
    end
  end

  always_ff @(posedge cs) begin
    if (reset) begin
      cnt_q          <= '0;
      run_max_q      <= '0;
      peak_q         <= '0;
      close_q        <= 1'b0;
      level_q        <= '0;
      volume_level_q <= '0;
      window_done_q  <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      run_max_q      <= run_max_d;
      peak_q         <= peak_d;
      close_q        <= close_d;
      level_q        <= level_d;
      volume_level_q <= volume_level_d;
      window_done_q  <= window_done_d;
    end
  end

  peak_hold_tracker #(
    .LW           (LW),
    .HOLD_WINDOWS (HOLD_WINDOWS)
  ) u_hold (
    .clk        (cs),
    .reset      (reset),
    .update     (close_q),
    .level_in   (lvl),
    .hold_level (hold_level)
  );

  assign level        = level_q;
  assign volume_level = volume_level_q;
  assign window_done  = window_done_q;

endmodule

// File: tb/tb_peak_level_meter.sv
// Bench for peak_level_meter: directed windows from the test plan plus a
// random phase, all checked each cycle against a window-level reference model.
module tb_peak_level_meter;

  localparam int unsigned SW    = 12;
  localparam int unsigned MID   = 2048;
  localparam int unsigned WIN   = 8;
  localparam int unsigned NL    = 16;
  localparam int unsigned SHIFT = 7;
  localparam int unsigned HOLD  = 2;
  localparam int unsigned LWT   = 5;

  logic            cs = 1'b0;
  logic            reset = 1'b1;
  logic            sample_valid = 1'b0;
  logic [SW-1:0]   sample = '0;
  logic [NL-1:0]   volume_level;
  logic [LWT-1:0]  level;
  logic [LWT-1:0]  hold_level;
  logic            window_done;

  peak_level_meter #(
    .SAMPLE_W     (SW),
    .MIDPOINT     (MID),
    .WINDOW       (WIN),
    .NUM_LEVELS   (NL),
    .LEVEL_SHIFT  (SHIFT),
    .HOLD_WINDOWS (HOLD)
  ) dut (
    .cs           (cs),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .volume_level (volume_level),
    .level        (level),
    .hold_level   (hold_level),
    .window_done  (window_done)
  );

  always #5 cs = ~cs;

  int unsigned checks = 0;
  int unsigned passes = 0;

  // Reference model state: magnitudes collected in the open window, the
  // peak waiting to be published, and the expected visible outputs.
  int unsigned win_q[$];
  bit          m_pend = 0;
  int unsigned m_peak = 0;
  int unsigned e_level = 0, e_bar = 0, e_hold = 0, e_done = 0;
  int unsigned m_hold_left = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_edge(input bit v, input int unsigned s, input bit r);
    int unsigned mag, lvl, pk;
    if (r) begin
      win_q.delete();
      m_pend = 0; m_peak = 0;
      e_level = 0; e_bar = 0; e_hold = 0; e_done = 0; m_hold_left = 0;
      return;
    end
    e_done = m_pend;
    if (m_pend) begin
      lvl = m_peak / (1 << SHIFT);
      if (lvl > NL) lvl = NL;
      e_level = lvl;
      e_bar   = (1 << lvl) - 1;
      if (lvl >= e_hold) begin
        e_hold = lvl; m_hold_left = HOLD;
      end else if (m_hold_left > 0) begin
        m_hold_left--;
      end else begin
        e_hold = (e_hold - 1 > lvl) ? e_hold - 1 : lvl;
      end
    end
    m_pend = 0;
    if (v) begin
      mag = (s >= MID) ? s - MID : MID - s;
      win_q.push_back(mag);
      if (win_q.size() == WIN) begin
        pk = 0;
        foreach (win_q[i]) if (win_q[i] > pk) pk = win_q[i];
        m_peak = pk;
        m_pend = 1;
        win_q.delete();
      end
    end
  endtask

  task automatic step(input bit v, input logic [SW-1:0] s, input bit r);
    sample_valid = v;
    sample       = s;
    reset        = r;
    @(posedge cs);
    model_edge(v, 32'(s), r);
    #1;
    chk("window_done", 32'(window_done), e_done);
    chk("level", 32'(level), e_level);
    chk("volume_level", 32'(volume_level), e_bar);
    chk("hold_level", 32'(hold_level), e_hold);
  endtask

  task automatic run_window(input logic [SW-1:0] s [8], input bit gappy);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, s[i], 1'b0);
      if (gappy) step(1'b0, '0, 1'b0);
    end
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
  endtask

  task automatic one_peak_window(input logic [SW-1:0] x);
    logic [SW-1:0] s [8];
    s[0] = x;
    for (int i = 1; i < 8; i++) s[i] = SW'(MID);
    run_window(s, 1'b0);
  endtask

  logic [SW-1:0] ramp [8];

  initial begin
    ramp = '{12'd2048, 12'd2100, 12'd2300, 12'd2048, 12'd2048, 12'd2048, 12'd2048, 12'd3000};

    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_bar", 32'(volume_level), 32'd0);
    chk("reset_hold", 32'(hold_level), 32'd0);

    // Reset mid-window discards the partial window.
    for (int i = 0; i < 5; i++) step(1'b1, 12'd4000, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 12'd0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 12'd2048, 1'b0);
    chk("no_early_done", 32'(window_done), 32'd0);
    step(1'b1, 12'd2048, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("reset_window_done", 32'(window_done), 32'd1);

    // Ramp window.
    run_window(ramp, 1'b0);
    chk("ramp_level", 32'(level), 32'd7);
    chk("ramp_bar", 32'(volume_level), 32'h007F);

    // Negative swing / saturation.
    one_peak_window(12'd0);
    chk("sat_level", 32'(level), 32'd16);
    chk("sat_bar", 32'(volume_level), 32'hFFFF);
    one_peak_window(12'd1152);
    chk("neg_level", 32'(level), 32'd7);

    // Inclusive thresholds.
    one_peak_window(12'd2815);
    chk("thr767", 32'(level), 32'd5);
    one_peak_window(12'd2816);
    chk("thr768", 32'(level), 32'd6);

    // Valid gating with garbage on idle cycles.
    run_window(ramp, 1'b1);
    chk("gap_level", 32'(level), 32'd7);
    chk("gap_bar", 32'(volume_level), 32'h007F);

    // Reset coinciding with the closing sample: no window_done.
    for (int i = 0; i < 7; i++) step(1'b1, 12'd3000, 1'b0);
    step(1'b1, 12'd3000, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("reset_close_done", 32'(window_done), 32'd0);
    chk("reset_close_level", 32'(level), 32'd0);

    // Peak hold: 10,3,3,3,3,3 then 12.
    one_peak_window(12'd3328);
    chk("hold_w1", 32'(hold_level), 32'd10);
    one_peak_window(12'd2432);
    chk("hold_w2", 32'(hold_level), 32'd10);
    one_peak_window(12'd2432);
    chk("hold_w3", 32'(hold_level), 32'd10);
    one_peak_window(12'd2432);
    chk("hold_w4", 32'(hold_level), 32'd9);
    one_peak_window(12'd2432);
    chk("hold_w5", 32'(hold_level), 32'd8);
    one_peak_window(12'd2432);
    chk("hold_w6", 32'(hold_level), 32'd7);
    chk("hold_live", 32'(level), 32'd3);
    one_peak_window(12'd3584);
    chk("hold_w7", 32'(hold_level), 32'd12);

    // Random phase: mixed amplitude, random gaps, rare resets.
    for (int i = 0; i < 1500; i++) begin
      bit            v, r;
      int unsigned   amp;
      logic [SW-1:0] s;
      v   = ($urandom_range(0, 9) < 7);
      r   = ($urandom_range(0, 299) == 0);
      amp = $urandom_range(0, ($urandom_range(0, 3) == 0) ? 2048 : 1200);
      s   = $urandom_range(0, 1) ? SW'(MID + ((amp > 2047) ? 2047 : amp)) : SW'(MID - amp);
      step(v, s, r);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
